// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and the
// memory address-exception encoding used by the M-stage exception logic.
package cp0_pkg;

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegSr       = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;
  localparam logic [4:0] RegPrid     = 5'd15;

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;
  localparam logic [4:0] ExcRi   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;

  typedef enum logic [1:0] {
    MemExcNone     = 2'b00,
    MemExcLoadErr  = 2'b10,
    MemExcStoreErr = 2'b11
  } mem_exc_e;

  // Architecturally visible SR fields; everything else reads as zero.
  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

endpackage

// File: rtl/cp0_exc_unit_if.sv
// M-stage pipeline <-> CP0 signal bundle (mfc0/mtc0/eret, trap inputs, redirect outputs).
interface cp0_exc_unit_if;
  logic [4:0]  reg_addr;
  logic [31:0] wdata;
  logic        we;
  logic        exl_clr;
  logic [31:0] pc_in;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [1:0]  mem_addr_exc;
  logic [31:0] mem_addr;
  logic [5:0]  hw_int;
  logic        irq;
  logic [31:0] exc_pc_out;
  logic [31:0] epc_out;
  logic [31:0] rdata;

  modport master (
    output reg_addr, wdata, we, exl_clr, pc_in, bd_in, exc_code_in, mem_addr_exc,
           mem_addr, hw_int,
    input  irq, exc_pc_out, epc_out, rdata
  );

  modport slave (
    input  reg_addr, wdata, we, exl_clr, pc_in, bd_in, exc_code_in, mem_addr_exc,
           mem_addr, hw_int,
    output irq, exc_pc_out, epc_out, rdata
  );
endinterface

// File: rtl/cp0_exc_sel.sv
// Trap priority encoder: decides interrupt vs exception, the ExcCode to record
// and whether BadVAddr should capture the data address.
module cp0_exc_sel
  import cp0_pkg::*;
(
  input  logic [4:0] exc_code_i,
  input  logic [1:0] mem_addr_exc_i,
  input  logic [5:0] hw_int_i,
  input  sr_t        sr_i,
  output logic       int_req_o,
  output logic       exc_req_o,
  output logic [4:0] code_o,
  output logic       bad_va_load_o
);

  logic [4:0] sel_code;
  logic       has_exc;
  logic       from_mem;

  always_comb begin
    sel_code = ExcInt;
    has_exc  = 1'b0;
    from_mem = 1'b0;
    // Piped-down codes are older in program order than the M-stage address fault.
    if (exc_code_i != ExcInt) begin
      sel_code = exc_code_i;
      has_exc  = 1'b1;
    end else if (mem_addr_exc_i == MemExcLoadErr) begin
      sel_code = ExcAdEL;
      has_exc  = 1'b1;
      from_mem = 1'b1;
    end else if (mem_addr_exc_i == MemExcStoreErr) begin
      sel_code = ExcAdES;
      has_exc  = 1'b1;
      from_mem = 1'b1;
    end

    int_req_o     = (|(hw_int_i & sr_i.im)) & sr_i.ie & ~sr_i.exl;
    exc_req_o     = has_exc & ~sr_i.exl;
    code_o        = int_req_o ? ExcInt : sel_code;
    bad_va_load_o = exc_req_o & ~int_req_o & from_mem;
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 / exception capture at the M stage: holds SR, Cause, EPC and
// BadVAddr, raises the same-cycle trap request and serves mfc0/mtc0/eret.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID      = 32'h0000_8086,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic           clk,
  input  logic           reset_n,
  cp0_exc_unit_if.slave  bus
);

  sr_t         sr_q, sr_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badva_q, badva_d;

  logic        int_req;
  logic        exc_req;
  logic        irq;
  logic [4:0]  trap_code;
  logic        bad_va_load;
  logic [31:0] trap_pc;
  logic        unused_trap_pc;

  cp0_exc_sel u_exc_sel (
    .exc_code_i     (bus.exc_code_in),
    .mem_addr_exc_i (bus.mem_addr_exc),
    .hw_int_i       (bus.hw_int),
    .sr_i           (sr_q),
    .int_req_o      (int_req),
    .exc_req_o      (exc_req),
    .code_o         (trap_code),
    .bad_va_load_o  (bad_va_load)
  );

  assign irq            = int_req | exc_req;
  // A delay-slot instruction restarts at its branch.
  assign trap_pc        = bus.bd_in ? (bus.pc_in - 32'd4) : bus.pc_in;
  assign unused_trap_pc = ^trap_pc[1:0];

  always_comb begin
    sr_d       = sr_q;
    bd_d       = bd_q;
    ip_d       = bus.hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badva_d    = badva_q;
    if (irq) begin
      // Trap commit overrides any mtc0 issued in the same cycle.
      sr_d.exl   = 1'b1;
      exc_code_d = trap_code;
      bd_d       = bus.bd_in;
      epc_d      = {trap_pc[31:2], 2'b00};
      if (bad_va_load) begin
        badva_d = bus.mem_addr;
      end
    end else begin
      if (bus.we && (bus.reg_addr == RegSr)) begin
        sr_d = '{im: bus.wdata[15:10], exl: bus.wdata[1], ie: bus.wdata[0]};
      end
      if (bus.we && (bus.reg_addr == RegEpc)) begin
        epc_d = {bus.wdata[31:2], 2'b00};
      end
      if (bus.exl_clr) begin
        sr_d.exl = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q       <= '0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badva_q    <= '0;
    end else begin
      sr_q       <= sr_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badva_q    <= badva_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.reg_addr)
      RegSr:       bus.rdata = {16'b0, sr_q.im, 8'b0, sr_q.exl, sr_q.ie};
      RegCause:    bus.rdata = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
      RegEpc:      bus.rdata = epc_q;
      RegBadVAddr: bus.rdata = badva_q;
      RegPrid:     bus.rdata = PRID;
      default:     bus.rdata = '0;
    endcase
  end

  assign bus.irq        = irq;
  assign bus.exc_pc_out = EXC_ENTRY;
  assign bus.epc_out    = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed and random checks of cp0_exc_unit against a register-level model.
module tb_cp0_exc_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cp0_exc_unit_if bus ();

  cp0_exc_unit #(
    .PRID      (32'h0000_8086),
    .EXC_ENTRY (32'h0000_4180)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  localparam logic [31:0] ExpPrid  = 32'h0000_8086;
  localparam logic [31:0] ExpEntry = 32'h0000_4180;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: full 32-bit architectural register images.
  logic [31:0] m_sr, m_cause, m_epc, m_bva;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sr = '0; m_cause = '0; m_epc = '0; m_bva = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd8:    return m_bva;
      5'd15:   return ExpPrid;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_reqs(output logic ireq, output logic ereq,
                                 output logic [4:0] code, output logic from_mem);
    logic ie, exl;
    logic [5:0] im;
    logic has;
    ie  = m_sr[0];
    exl = m_sr[1];
    im  = m_sr[15:10];
    from_mem = 1'b0;
    has = 1'b1;
    if (bus.exc_code_in != 0) code = bus.exc_code_in;
    else if (bus.mem_addr_exc == 2'b10) begin code = 5'd4; from_mem = 1'b1; end
    else if (bus.mem_addr_exc == 2'b11) begin code = 5'd5; from_mem = 1'b1; end
    else begin code = 5'd0; has = 1'b0; end
    ireq = ((bus.hw_int & im) != 0) && ie && !exl;
    ereq = has && !exl;
  endfunction

  task automatic idle();
    bus.we = 0; bus.exl_clr = 0; bus.wdata = '0; bus.pc_in = '0; bus.bd_in = 0;
    bus.exc_code_in = '0; bus.mem_addr_exc = 2'b00; bus.mem_addr = '0; bus.hw_int = '0;
  endtask

  // Called just after a falling edge with inputs applied; checks outputs, clocks once.
  task automatic step();
    logic ireq, ereq, fm;
    logic [4:0] code;
    logic [31:0] n_sr, n_cause, n_epc, n_bva, tpc;
    #1;
    m_reqs(ireq, ereq, code, fm);
    chk("irq", {31'b0, bus.irq}, {31'b0, ireq | ereq});
    chk("rdata", bus.rdata, m_read(bus.reg_addr));
    chk("epc_out", bus.epc_out, m_epc);
    chk("exc_pc_out", bus.exc_pc_out, ExpEntry);
    n_sr = m_sr; n_cause = m_cause; n_epc = m_epc; n_bva = m_bva;
    n_cause[15:10] = bus.hw_int;
    if (ireq || ereq) begin
      n_sr[1] = 1'b1;
      n_cause[6:2] = ireq ? 5'd0 : code;
      n_cause[31] = bus.bd_in;
      tpc = bus.bd_in ? bus.pc_in - 32'd4 : bus.pc_in;
      n_epc = tpc & ~32'd3;
      if (!ireq && fm) n_bva = bus.mem_addr;
    end else begin
      if (bus.we && bus.reg_addr == 5'd12) n_sr = bus.wdata & 32'h0000_FC03;
      if (bus.we && bus.reg_addr == 5'd14) n_epc = bus.wdata & ~32'd3;
      if (bus.exl_clr) n_sr[1] = 1'b0;
    end
    @(posedge clk);
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc; m_bva = n_bva;
    @(negedge clk);
  endtask

  // Read a register against a spec-derived constant, then spend one idle cycle.
  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.reg_addr = a;
    #1;
    chk(tag, bus.rdata, exp);
    step();
  endtask

  initial begin
    logic [4:0] addrs [6];
    addrs[0] = 5'd8; addrs[1] = 5'd12; addrs[2] = 5'd13;
    addrs[3] = 5'd14; addrs[4] = 5'd15; addrs[5] = 5'd3;

    idle();
    bus.reg_addr = 5'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    peek("rst_sr", 5'd12, 32'h0);
    peek("rst_cause", 5'd13, 32'h0);
    peek("rst_epc", 5'd14, 32'h0);
    peek("rst_bva", 5'd8, 32'h0);
    peek("prid", 5'd15, ExpPrid);
    peek("unknown_reg", 5'd3, 32'h0);

    // Interrupt path.
    bus.we = 1; bus.reg_addr = 5'd12; bus.wdata = 32'h0000_FC01;
    step();
    idle(); bus.hw_int = 6'b000001; bus.pc_in = 32'h0000_1000;
    #1 chk("int_irq", {31'b0, bus.irq}, 32'd1);
    step();
    idle();
    peek("int_cause", 5'd13, 32'h0000_0400);
    peek("int_sr", 5'd12, 32'h0000_FC03);
    peek("int_epc", 5'd14, 32'h0000_1000);
    bus.hw_int = 6'b000001;
    #1 chk("nested_irq", {31'b0, bus.irq}, 32'd0);
    step();
    idle(); bus.exl_clr = 1; bus.we = 1; bus.reg_addr = 5'd12; bus.wdata = 32'h0000_FC03;
    step();
    idle();
    peek("exlclr_wins", 5'd12, 32'h0000_FC01);
    bus.we = 1; bus.reg_addr = 5'd12; bus.wdata = 32'h0;
    step();

    // Store address fault.
    idle(); bus.mem_addr_exc = 2'b11; bus.mem_addr = 32'h0000_7F08; bus.pc_in = 32'h0000_3010;
    #1 chk("ades_irq", {31'b0, bus.irq}, 32'd1);
    step();
    idle();
    peek("ades_cause", 5'd13, 32'h0000_0014);
    peek("ades_bva", 5'd8, 32'h0000_7F08);
    peek("ades_epc", 5'd14, 32'h0000_3010);
    bus.exl_clr = 1;
    step();

    // Load fault in a delay slot.
    idle(); bus.mem_addr_exc = 2'b10; bus.mem_addr = 32'h0000_3001;
    bus.pc_in = 32'h0000_3024; bus.bd_in = 1;
    step();
    idle();
    peek("adel_cause", 5'd13, 32'h8000_0010);
    peek("adel_epc", 5'd14, 32'h0000_3020);
    peek("adel_bva", 5'd8, 32'h0000_3001);
    bus.exl_clr = 1;
    step();

    // Interrupt beats a piped overflow.
    idle(); bus.we = 1; bus.reg_addr = 5'd12; bus.wdata = 32'h0000_FC01;
    step();
    idle(); bus.exc_code_in = 5'd12; bus.hw_int = 6'b000100; bus.pc_in = 32'h0000_2000;
    step();
    idle();
    peek("intov_cause", 5'd13, 32'h0000_1000);
    peek("intov_bva", 5'd8, 32'h0000_3001);
    bus.exl_clr = 1;
    step();

    // mtc0 EPC colliding with a trap is dropped.
    idle(); bus.we = 1; bus.reg_addr = 5'd14; bus.wdata = 32'h0000_4000;
    bus.exc_code_in = 5'd10; bus.pc_in = 32'h0000_2400;
    step();
    idle();
    peek("mtc0_drop_epc", 5'd14, 32'h0000_2400);
    peek("ri_cause", 5'd13, 32'h0000_0028);

    // eret, then asynchronous reset mid-cycle.
    bus.exl_clr = 1;
    step();
    idle();
    peek("eret_sr", 5'd12, 32'h0000_FC01);
    chk("eret_epc", bus.epc_out, 32'h0000_2400);
    bus.reg_addr = 5'd12;
    #2 reset_n = 1'b0;
    #1 chk("arst_sr", bus.rdata, 32'h0);
    chk("arst_epc_out", bus.epc_out, 32'h0);
    bus.reg_addr = 5'd13;
    #1 chk("arst_cause", bus.rdata, 32'h0);
    bus.reg_addr = 5'd8;
    #1 chk("arst_bva", bus.rdata, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.reg_addr     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 5)];
      bus.we           = ($urandom_range(0, 3) == 0);
      bus.wdata        = $urandom;
      bus.exl_clr      = ($urandom_range(0, 7) == 0);
      bus.pc_in        = $urandom;
      bus.bd_in        = 1'($urandom);
      bus.exc_code_in  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      bus.mem_addr_exc = 2'($urandom);
      bus.mem_addr     = $urandom;
      bus.hw_int       = 6'($urandom & $urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
